sprite_rom_router: RTL and testbench
====================================

Name: sprite_rom_router

Overview:
- Parametrised, pipelined successor to the combinational sprite-memory selector.
- Routes one pixel-read request per cycle to one of N_CH sprite ROMs (background, buttons, win/lose screens, …) using a per-channel read enable instead of a gated clock.
- Carries channel tag and range status alongside the ROM latency and returns the selected pixel with a valid strobe and a transparency flag.
- Sits between the VGA pixel compositor and the altsyncram sprite ROMs.

Parameters:
- N_CH, 8, number of sprite ROM channels (2..16)
- SEL_W, 3, selector width; must satisfy 2^SEL_W >= N_CH
- ADDR_W, 16, request/ROM address width
- PX_W, 16, pixel width
- ROM_LAT, 1, ROM read latency in cycles from registered address to data (1..4)
- CH_DEPTH, {8{16'hFFFF}}, packed N_CH*ADDR_W vector; channel i word count in slice i
- DEFAULT_PX, 16'h0000, pixel returned for rejected requests
- KEY_PX, 16'hF81F, transparency colour key

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- IN_REQ  in  1  read request this cycle
- IN_SEL  in  SEL_W  target channel
- IN_ADDR  in  ADDR_W  word address within channel
- FLUSH  in  1  discard all in-flight reads
- ROM_RDEN  out  N_CH  one-hot read enable, registered
- ROM_ADDR  out  ADDR_W  shared ROM address, registered
- ROM_DATA  in  N_CH*PX_W  packed ROM outputs; channel i in slice i
- OUT_VALID  out  1  OUT_PX/OUT_SEL/OUT_OOR/OUT_OPAQUE valid this cycle
- OUT_PX  out  PX_W  returned pixel
- OUT_SEL  out  SEL_W  channel tag of the returned pixel
- OUT_OOR  out  1  request was rejected (bad channel or address)
- OUT_OPAQUE  out  1  OUT_VALID & ~OUT_OOR & (OUT_PX != KEY_PX)
- BUSY  out  1  at least one read in flight

Behaviour:
- One clock, CLK. Reset is synchronous, active-low (RST_N). Every output resets to 0, and all pipeline valid bits clear. Reset mid-operation drops all in-flight reads with no OUT_VALID.
- No back-pressure. A request is accepted on every edge where IN_REQ=1, so throughput is 1 per cycle.
- Range check at acceptance (edge k): reject if IN_SEL >= N_CH or IN_ADDR >= CH_DEPTH[IN_SEL]. The compare is unsigned and ADDR_W wide.
- Accepted in-range request: after edge k, ROM_RDEN has only bit IN_SEL set and ROM_ADDR = IN_ADDR.
- Rejected request: ROM_RDEN = 0 after edge k, ROM_ADDR holds its value, and the tag still enters the pipeline with OOR=1.
- Idle cycle (IN_REQ=0): ROM_RDEN = 0 and ROM_ADDR holds its last value.
- Tag pipeline: {valid, sel, oor}, depth ROM_LAT+1, shift register.
- Output: after edge k+ROM_LAT+1, OUT_VALID=1 and OUT_SEL=tag sel. OUT_PX = DEFAULT_PX if oor, otherwise the ROM_DATA slice[sel] sampled at that edge.
- Latency is exactly ROM_LAT+1 cycles from the accepting edge to OUT_VALID. Order is preserved.
- When OUT_VALID=0, OUT_PX, OUT_SEL and OUT_OOR hold their last values and OUT_OPAQUE=0.
- Back-to-back requests to different channels are fully pipelined. Each result uses its own tag; there is no cross-channel hazard.
- FLUSH=1 at edge k:
  - Clears every pipeline valid bit and drops a simultaneous IN_REQ. FLUSH wins over IN_REQ.
  - ROM_RDEN=0 after edge k.
  - OUT_VALID=0 after edge k and for ROM_LAT further cycles unless new requests arrive.
- BUSY = OR of pipeline valid bits, excluding the output register.
- Selector values >= N_CH never raise any ROM_RDEN bit.

Decomposition:
- Shared package genius_pkg:
  - channel index constants (BACKGROUND=0 … LOSE_SCREEN=7)
  - default CH_DEPTH vector built from sprite sizes (64800, 231, 14196, 14112, 14028, 14028, 20880, 24120)
  - KEY_PX constant
- Sub-module tag_pipe: parametrised width/depth valid-data shift register with synchronous flush; instantiated once for {sel, oor}.

Test Plan:
- Reset: RST_N=0 for 3 cycles with IN_REQ=1 → ROM_RDEN=0, OUT_VALID=0, BUSY=0. Release, then IN_REQ sel=0 addr=100 → ROM_RDEN=8'b0000_0001, ROM_ADDR=100; 2 cycles later (ROM_LAT=1) OUT_VALID=1 and OUT_PX equals ROM model word 100.
- Streaming: 8 consecutive requests sel=0..7, addr=5 → ROM_RDEN walks one-hot across 8 cycles; OUT_SEL returns 0..7 in order on consecutive cycles with no bubbles.
- Range: sel=1 addr=231 (depth 231) → no ROM_RDEN, OUT_OOR=1, OUT_PX=16'h0000, OUT_OPAQUE=0. sel=1 addr=230 → OUT_OOR=0.
- Transparency: ROM model returns 16'hF81F at sel=2 addr=0 → OUT_OPAQUE=0. Returns 16'h07E0 at sel=2 addr=1 → OUT_OPAQUE=1.
- Flush: request issued, then FLUSH=1 together with a second request one cycle later → neither produces OUT_VALID; BUSY=0 after the flush edge; the next request returns normally.
- Latency sweep: ROM_LAT=1..4 with N_CH=4, SEL_W=2 → OUT_VALID exactly ROM_LAT+1 cycles after the accepting edge; sel=3 is accepted; sel values >= 4 are not possible at SEL_W=2.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared sprite-memory definitions: channel indices, sprite ROM word counts
// and the colour key used to mark transparent pixels.
package genius_pkg;

  typedef enum logic [2:0] {
    BACKGROUND  = 3'd0,
    CURSOR      = 3'd1,
    BTN_GREEN   = 3'd2,
    BTN_RED     = 3'd3,
    BTN_YELLOW  = 3'd4,
    BTN_BLUE    = 3'd5,
    WIN_SCREEN  = 3'd6,
    LOSE_SCREEN = 3'd7
  } sprite_ch_e;

  localparam int unsigned SPRITE_N_CH = 8;

  // Slice i (ADDR_W=16 bits each, LSB first) holds the word count of channel i
  localparam logic [SPRITE_N_CH*16-1:0] SPRITE_CH_DEPTH = {
    16'd24120, 16'd20880, 16'd14028, 16'd14028,
    16'd14112, 16'd14196, 16'd231,   16'd64800
  };

  localparam logic [15:0] SPRITE_KEY_PX = 16'hF81F;

endpackage

// File: rtl/sprite_rom_router_tag_pipe.sv
// Valid/data shift register that carries request tags alongside ROM latency;
// flush clears every valid bit but leaves the data words untouched.
module tag_pipe #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         any_valid
);

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0][W-1:0] data_q, data_d;

  always_comb begin
    valid_d   = '0;
    data_d    = data_q;
    data_d[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      data_d[i] = data_q[i-1];
    end
    if (!flush) begin
      valid_d[0] = in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/sprite_rom_router.sv
// Routes one pixel read per cycle to one of N_CH sprite ROMs through per-channel
// read enables and returns the pixel tagged with its channel and range status.
module sprite_rom_router
  import genius_pkg::*;
#(
  parameter int unsigned             N_CH       = 8,
  parameter int unsigned             SEL_W      = 3,
  parameter int unsigned             ADDR_W     = 16,
  parameter int unsigned             PX_W       = 16,
  parameter int unsigned             ROM_LAT    = 1,
  parameter logic [N_CH*ADDR_W-1:0]  CH_DEPTH   = {N_CH{ {ADDR_W{1'b1}} }},
  parameter logic [PX_W-1:0]         DEFAULT_PX = '0,
  parameter logic [PX_W-1:0]         KEY_PX     = PX_W'(SPRITE_KEY_PX)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_REQ,
  input  logic [SEL_W-1:0]     IN_SEL,
  input  logic [ADDR_W-1:0]    IN_ADDR,
  input  logic                 FLUSH,
  output logic [N_CH-1:0]      ROM_RDEN,
  output logic [ADDR_W-1:0]    ROM_ADDR,
  input  logic [N_CH*PX_W-1:0] ROM_DATA,
  output logic                 OUT_VALID,
  output logic [PX_W-1:0]      OUT_PX,
  output logic [SEL_W-1:0]     OUT_SEL,
  output logic                 OUT_OOR,
  output logic                 OUT_OPAQUE,
  output logic                 BUSY
);

  localparam int unsigned TAG_W = SEL_W + 1;

  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] ch_depth;
  logic [N_CH-1:0]   rom_rden_d, rom_rden_q;
  logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;

  logic              tag_valid;
  logic [TAG_W-1:0]  tag_data;
  logic [SEL_W-1:0]  tag_sel;
  logic              tag_oor;
  logic [PX_W-1:0]   rom_px;

  logic              out_valid_d, out_valid_q;
  logic [PX_W-1:0]   out_px_d, out_px_q;
  logic [SEL_W-1:0]  out_sel_d, out_sel_q;
  logic              out_oor_d, out_oor_q;

  // Depth lookup by loop so selector codes >= N_CH never index past CH_DEPTH
  always_comb begin
    accept   = IN_REQ & ~FLUSH;
    ch_depth = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(IN_SEL) == i) ch_depth = CH_DEPTH[i*ADDR_W +: ADDR_W];
    end
    in_range   = (32'(IN_SEL) < N_CH) && (IN_ADDR < ch_depth);
    rom_rden_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      rom_rden_d[i] = accept & in_range & (32'(IN_SEL) == i);
    end
    rom_addr_d = (accept && in_range) ? IN_ADDR : rom_addr_q;
  end

  tag_pipe #(
    .W     (TAG_W),
    .DEPTH (ROM_LAT + 1)
  ) u_tag_pipe (
    .clk       (CLK),
    .rst_n     (RST_N),
    .flush     (FLUSH),
    .in_valid  (accept),
    .in_data   ({IN_SEL, ~in_range}),
    .out_valid (tag_valid),
    .out_data  (tag_data),
    .any_valid (BUSY)
  );

  assign tag_sel = tag_data[TAG_W-1:1];
  assign tag_oor = tag_data[0];

  always_comb begin
    rom_px = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(tag_sel) == i) rom_px = ROM_DATA[i*PX_W +: PX_W];
    end
    out_valid_d = tag_valid & ~FLUSH;
    out_px_d    = out_px_q;
    out_sel_d   = out_sel_q;
    out_oor_d   = out_oor_q;
    if (out_valid_d) begin
      out_px_d  = tag_oor ? DEFAULT_PX : rom_px;
      out_sel_d = tag_sel;
      out_oor_d = tag_oor;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rom_rden_q  <= '0;
      rom_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_px_q    <= '0;
      out_sel_q   <= '0;
      out_oor_q   <= 1'b0;
    end else begin
      rom_rden_q  <= rom_rden_d;
      rom_addr_q  <= rom_addr_d;
      out_valid_q <= out_valid_d;
      out_px_q    <= out_px_d;
      out_sel_q   <= out_sel_d;
      out_oor_q   <= out_oor_d;
    end
  end

  assign ROM_RDEN   = rom_rden_q;
  assign ROM_ADDR   = rom_addr_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_PX     = out_px_q;
  assign OUT_SEL    = out_sel_q;
  assign OUT_OOR    = out_oor_q;
  assign OUT_OPAQUE = out_valid_q & ~out_oor_q & (out_px_q != KEY_PX);

endmodule

// File: tb/tb_sprite_rom_router.sv
// Bench for sprite_rom_router: six configurations share one stimulus stream,
// each checked every cycle against a queue-based model of request results.
module tb_sprite_rom_router;

  localparam logic [15:0] KEY = 16'hF81F;

  typedef struct {
    int          due;
    logic [2:0]  sel;
    logic        oor;
    logic [15:0] px;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] addr;
    logic [7:0]  rden;
    logic        oor;
    logic [15:0] px;
    logic        opq;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_req;
  logic [2:0]  in_sel;
  logic [15:0] in_addr;
  logic        flush;

  int checks = 0;
  int errors = 0;
  int depths [8] = '{64800, 231, 14196, 14112, 14028, 14028, 20880, 24120};

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input int ch, input logic [15:0] a);
    if (ch == 2 && a == 16'd0) return 16'hF81F;
    if (ch == 2 && a == 16'd1) return 16'h07E0;
    if (a[3:0] == 4'hF) return KEY;
    return 16'(ch * 4099 + int'(a) * 37 + 11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cfg0: N_CH=8 ROM_LAT=1; cfg1..4: N_CH=4 ROM_LAT=1..4; cfg5: N_CH=6 ROM_LAT=2
  for (genvar g = 0; g < 6; g++) begin : g_cfg
    localparam int NCH = (g == 0) ? 8 : (g == 5) ? 6 : 4;
    localparam int SW  = (NCH == 4) ? 2 : 3;
    localparam int L   = (g == 0) ? 1 : (g == 5) ? 2 : g;

    logic [NCH-1:0]    rden;
    logic [15:0]       raddr;
    logic [NCH*16-1:0] rdata;
    logic              out_valid, out_oor, out_opaque, busy;
    logic [15:0]       out_px;
    logic [SW-1:0]     out_sel;
    logic [15:0]       rom_st [NCH][L];

    sprite_rom_router #(
      .N_CH       (NCH),
      .SEL_W      (SW),
      .ADDR_W     (16),
      .PX_W       (16),
      .ROM_LAT    (L),
      .CH_DEPTH   (genius_pkg::SPRITE_CH_DEPTH[NCH*16-1:0]),
      .DEFAULT_PX (16'h0000),
      .KEY_PX     (16'hF81F)
    ) u_dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .IN_REQ     (in_req),
      .IN_SEL     (in_sel[SW-1:0]),
      .IN_ADDR    (in_addr),
      .FLUSH      (flush),
      .ROM_RDEN   (rden),
      .ROM_ADDR   (raddr),
      .ROM_DATA   (rdata),
      .OUT_VALID  (out_valid),
      .OUT_PX     (out_px),
      .OUT_SEL    (out_sel),
      .OUT_OOR    (out_oor),
      .OUT_OPAQUE (out_opaque),
      .BUSY       (busy)
    );

    // ROM: word latched on its read enable, then L-1 further output stages
    always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
        if (rden[c]) rom_st[c][0] <= rom_fn(c, raddr);
        for (int s = 1; s < L; s++) rom_st[c][s] <= rom_st[c][s-1];
      end
    end

    always_comb begin
      rdata = '0;
      for (int c = 0; c < NCH; c++) rdata[c*16 +: 16] = rom_st[c][L-1];
    end

    exp_t           q[$];
    int             e_n = 0;
    logic [NCH-1:0] exp_rden = '0;
    logic [15:0]    exp_addr = '0;
    logic [2:0]     last_sel = '0;
    logic           last_oor = 1'b0;
    logic [15:0]    last_px  = '0;

    // Check the state after edge e_n, then fold in the inputs for edge e_n+1
    always @(negedge clk) begin
      exp_t x;
      int   s;
      logic o;
      e_n++;
      if (q.size() > 0 && q[0].due == e_n) begin
        x = q.pop_front();
        chk($sformatf("cfg%0d valid", g), 32'(out_valid), 32'd1);
        chk($sformatf("cfg%0d sel", g), 32'(out_sel), 32'(x.sel));
        chk($sformatf("cfg%0d oor", g), 32'(out_oor), 32'(x.oor));
        chk($sformatf("cfg%0d px", g), 32'(out_px), 32'(x.px));
        chk($sformatf("cfg%0d opaque", g), 32'(out_opaque), 32'(!x.oor && x.px != KEY));
        last_sel = x.sel;
        last_oor = x.oor;
        last_px  = x.px;
      end else begin
        chk($sformatf("cfg%0d idle valid", g), 32'(out_valid), 32'd0);
        chk($sformatf("cfg%0d idle opaque", g), 32'(out_opaque), 32'd0);
        chk($sformatf("cfg%0d hold sel", g), 32'(out_sel), 32'(last_sel));
        chk($sformatf("cfg%0d hold oor", g), 32'(out_oor), 32'(last_oor));
        chk($sformatf("cfg%0d hold px", g), 32'(out_px), 32'(last_px));
      end
      chk($sformatf("cfg%0d rden", g), 32'(rden), 32'(exp_rden));
      chk($sformatf("cfg%0d addr", g), 32'(raddr), 32'(exp_addr));
      chk($sformatf("cfg%0d busy", g), 32'(busy), 32'(q.size() != 0));

      if (!rst_n) begin
        q.delete();
        exp_rden = '0;
        exp_addr = '0;
        last_sel = '0;
        last_oor = 1'b0;
        last_px  = '0;
      end else if (flush) begin
        q.delete();
        exp_rden = '0;
      end else begin
        exp_rden = '0;
        if (in_req) begin
          s = int'(in_sel[SW-1:0]);
          o = (s >= NCH) || (int'(in_addr) >= depths[s]);
          if (!o) begin
            exp_rden[s] = 1'b1;
            exp_addr    = in_addr;
          end
          x.due = e_n + 1 + L + 1;
          x.sel = 3'(s);
          x.oor = o;
          x.px  = o ? 16'h0000 : rom_fn(s, in_addr);
          q.push_back(x);
        end
      end
    end
  end

  vec_t vecs [8];

  initial begin
    vecs[0] = '{3'd1, 16'd231,   8'h00, 1'b1, 16'h0000,            1'b0};
    vecs[1] = '{3'd1, 16'd230,   8'h02, 1'b0, rom_fn(1, 16'd230),  rom_fn(1, 16'd230) != KEY};
    vecs[2] = '{3'd2, 16'd0,     8'h04, 1'b0, 16'hF81F,            1'b0};
    vecs[3] = '{3'd2, 16'd1,     8'h04, 1'b0, 16'h07E0,            1'b1};
    vecs[4] = '{3'd7, 16'd24119, 8'h80, 1'b0, rom_fn(7, 16'd24119), rom_fn(7, 16'd24119) != KEY};
    vecs[5] = '{3'd7, 16'd24120, 8'h00, 1'b1, 16'h0000,            1'b0};
    vecs[6] = '{3'd0, 16'd64799, 8'h01, 1'b0, rom_fn(0, 16'd64799), rom_fn(0, 16'd64799) != KEY};
    vecs[7] = '{3'd0, 16'd64800, 8'h00, 1'b1, 16'h0000,            1'b0};

    // Reset held with a request pending
    rst_n = 1'b0; in_req = 1'b1; in_sel = 3'd0; in_addr = 16'd100; flush = 1'b0;
    repeat (3) tick();
    chk("reset rden", 32'(g_cfg[0].rden), 32'd0);
    chk("reset valid", 32'(g_cfg[0].out_valid), 32'd0);
    chk("reset busy", 32'(g_cfg[0].busy), 32'd0);

    // First request after reset
    rst_n = 1'b1;
    tick();
    chk("first rden", 32'(g_cfg[0].rden), 32'h01);
    chk("first addr", 32'(g_cfg[0].raddr), 32'd100);
    in_req = 1'b0;
    tick();
    chk("first early valid", 32'(g_cfg[0].out_valid), 32'd0);
    tick();
    chk("first valid", 32'(g_cfg[0].out_valid), 32'd1);
    chk("first px", 32'(g_cfg[0].out_px), 32'(rom_fn(0, 16'd100)));

    // Streaming across all channels, no bubbles
    for (int i = 0; i < 8; i++) begin
      in_req = 1'b1; in_sel = 3'(i); in_addr = 16'd5;
      tick();
      chk("stream rden", 32'(g_cfg[0].rden), 32'(1) << i);
      if (i >= 2) begin
        chk("stream valid", 32'(g_cfg[0].out_valid), 32'd1);
        chk("stream sel", 32'(g_cfg[0].out_sel), 32'(i - 2));
      end
    end
    in_req = 1'b0;
    for (int i = 6; i < 8; i++) begin
      tick();
      chk("stream tail valid", 32'(g_cfg[0].out_valid), 32'd1);
      chk("stream tail sel", 32'(g_cfg[0].out_sel), 32'(i));
    end
    tick();

    // Boundary and transparency vectors
    for (int v = 0; v < 8; v++) begin
      in_req = 1'b1; in_sel = vecs[v].sel; in_addr = vecs[v].addr;
      tick();
      chk("vec rden", 32'(g_cfg[0].rden), 32'(vecs[v].rden));
      if (!vecs[v].oor) chk("vec addr", 32'(g_cfg[0].raddr), 32'(vecs[v].addr));
      in_req = 1'b0;
      tick();
      tick();
      chk("vec valid", 32'(g_cfg[0].out_valid), 32'd1);
      chk("vec sel", 32'(g_cfg[0].out_sel), 32'(vecs[v].sel));
      chk("vec oor", 32'(g_cfg[0].out_oor), 32'(vecs[v].oor));
      chk("vec px", 32'(g_cfg[0].out_px), 32'(vecs[v].px));
      chk("vec opaque", 32'(g_cfg[0].out_opaque), 32'(vecs[v].opq));
    end

    // Flush beats a simultaneous request and kills the one in flight
    in_req = 1'b1; in_sel = 3'd3; in_addr = 16'd10;
    tick();
    chk("pre-flush busy", 32'(g_cfg[0].busy), 32'd1);
    flush = 1'b1; in_sel = 3'd4; in_addr = 16'd7;
    tick();
    chk("flush busy", 32'(g_cfg[0].busy), 32'd0);
    chk("flush rden", 32'(g_cfg[0].rden), 32'd0);
    chk("flush valid", 32'(g_cfg[0].out_valid), 32'd0);
    flush = 1'b0; in_req = 1'b0;
    tick();
    chk("flush drop A", 32'(g_cfg[0].out_valid), 32'd0);
    tick();
    chk("flush drop B", 32'(g_cfg[0].out_valid), 32'd0);
    in_req = 1'b1; in_sel = 3'd5; in_addr = 16'd9;
    tick();
    in_req = 1'b0;
    tick();
    tick();
    chk("post-flush valid", 32'(g_cfg[0].out_valid), 32'd1);
    chk("post-flush sel", 32'(g_cfg[0].out_sel), 32'd5);
    chk("post-flush px", 32'(g_cfg[0].out_px), 32'(rom_fn(5, 16'd9)));

    // Reset in the middle of a stream
    in_req = 1'b1; in_sel = 3'd6; in_addr = 16'd40;
    tick();
    in_sel = 3'd7;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midreset valid", 32'(g_cfg[0].out_valid), 32'd0);
    chk("midreset busy", 32'(g_cfg[0].busy), 32'd0);
    chk("midreset px", 32'(g_cfg[0].out_px), 32'd0);
    rst_n = 1'b1; in_req = 1'b0;
    tick();
    chk("midreset drop", 32'(g_cfg[0].out_valid), 32'd0);
    tick();

    // Random traffic, including rare flushes and resets
    for (int n = 0; n < 3000; n++) begin
      rst_n   = ($urandom_range(99) != 0);
      flush   = ($urandom_range(99) < 3);
      in_req  = ($urandom_range(99) < 75);
      in_sel  = 3'($urandom_range(7));
      case ($urandom_range(2))
        0:       in_addr = 16'($urandom);
        1:       in_addr = 16'(depths[in_sel] - 2 + int'($urandom_range(3)));
        default: in_addr = 16'($urandom_range(31));
      endcase
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; in_req = 1'b0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
